// File: rtl/apb4_pkg.sv
// Types and constants shared by the APB4 master bridge and the blocks that drive it.
// pprot bits: [0] privileged, [1] non-secure, [2] instruction.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_mst_state_e;

  localparam logic [2:0] PROT_PRIV  = 3'b001;
  localparam logic [2:0] PROT_NSEC  = 3'b010;
  localparam logic [2:0] PROT_INSTR = 3'b100;

endpackage

// File: rtl/apb4_master_bridge.sv
// Single-outstanding command/response to APB4 master bridge. It has an optional
// ACCESS-phase timeout, so a slave that never asserts pready cannot hang the bridge.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high, waiting for pready or timeout
// RESP   | rsp_valid high until rsp_ready
module apb4_master_bridge
  import apb4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_write_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;

  apb4_mst_state_e       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tout_q, tout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tout_d  = tout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = SETUP;
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          wdata_d = cmd_wdata_i;
          strb_d  = cmd_write_i ? cmd_strb_i : '0;
          prot_d  = cmd_prot_i;
          rdata_d = '0;
          err_d   = 1'b0;
          tout_d  = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // A same-cycle pready beats the timeout, so it is tested first.
        if (pready_i) begin
          state_d = RESP;
          rdata_d = write_q ? '0 : prdata_i;
          err_d   = pslverr_i;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign paddr_o       = addr_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = strb_q;
  assign pprot_o       = prot_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tout_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Bench for apb4_master_bridge: a default-timeout instance (A) and a TIMEOUT=4 instance (B)
// share stimulus; the instance under test is chosen by sel_b, and the other is drained between transfers.
module tb_apb4_master_bridge;

  localparam int TO_A = 256;
  localparam int TO_B = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        cmd_valid_i;
  logic [31:0] cmd_addr_i;
  logic        cmd_write_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic [2:0]  cmd_prot_i;
  logic        rsp_ready_i;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  logic        cmd_ready_a, rsp_valid_a, rsp_err_a, rsp_timeout_a, psel_a, penable_a, pwrite_a;
  logic [31:0] rsp_rdata_a, paddr_a, pwdata_a;
  logic [2:0]  pprot_a;
  logic [3:0]  pstrb_a;
  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, rsp_timeout_b, psel_b, penable_b, pwrite_b;
  logic [31:0] rsp_rdata_b, paddr_b, pwdata_b;
  logic [2:0]  pprot_b;
  logic [3:0]  pstrb_b;

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_a), .cmd_addr_i(cmd_addr_i),
    .cmd_write_i(cmd_write_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .cmd_prot_i(cmd_prot_i), .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_a), .rsp_err_o(rsp_err_a), .rsp_timeout_o(rsp_timeout_a),
    .paddr_o(paddr_a), .pprot_o(pprot_a), .psel_o(psel_a), .penable_o(penable_a),
    .pwrite_o(pwrite_a), .pwdata_o(pwdata_a), .pstrb_o(pstrb_a),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_b), .cmd_addr_i(cmd_addr_i),
    .cmd_write_i(cmd_write_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .cmd_prot_i(cmd_prot_i), .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b), .rsp_timeout_o(rsp_timeout_b),
    .paddr_o(paddr_b), .pprot_o(pprot_b), .psel_o(psel_b), .penable_o(penable_b),
    .pwrite_o(pwrite_b), .pwdata_o(pwdata_b), .pstrb_o(pstrb_b),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  logic        sel_b;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;

  assign cmd_ready   = sel_b ? cmd_ready_b   : cmd_ready_a;
  assign rsp_valid   = sel_b ? rsp_valid_b   : rsp_valid_a;
  assign rsp_err     = sel_b ? rsp_err_b     : rsp_err_a;
  assign rsp_timeout = sel_b ? rsp_timeout_b : rsp_timeout_a;
  assign psel        = sel_b ? psel_b        : psel_a;
  assign penable     = sel_b ? penable_b     : penable_a;
  assign pwrite      = sel_b ? pwrite_b      : pwrite_a;
  assign rsp_rdata   = sel_b ? rsp_rdata_b   : rsp_rdata_a;
  assign paddr       = sel_b ? paddr_b       : paddr_a;
  assign pwdata      = sel_b ? pwdata_b      : pwdata_a;
  assign pprot       = sel_b ? pprot_b       : pprot_a;
  assign pstrb       = sel_b ? pstrb_b       : pstrb_a;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut %s): actual=0x%0h required=0x%0h", nm, sel_b ? "B" : "A", act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: a slave that holds pready low for wait_n cycles either finishes
  // in wait_n+1 ACCESS cycles or, if that reaches the timeout, aborts after TIMEOUT cycles.
  function automatic void model(input int to, input logic wr, input int wait_n,
                                input logic [31:0] prd, input logic perr,
                                output logic [31:0] r, output logic e, output logic t,
                                output int acc);
    if (to != 0 && wait_n >= to) begin
      r = 32'h0; e = 1'b1; t = 1'b1; acc = to;
    end else begin
      r = wr ? 32'h0 : prd; e = perr; t = 1'b0; acc = wait_n + 1;
    end
  endfunction

  // Called at a falling edge with both DUTs idle; returns at a falling edge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                      input logic [31:0] prd, input logic perr, input int bp,
                      input logic [31:0] e_rdata, input logic e_err, input logic e_tout,
                      input int e_acc);
    int acc;
    logic [3:0] e_strb;
    e_strb = wr ? strb : 4'h0;
    chk("idle_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_write_i = wr;
    cmd_wdata_i = wdata;
    cmd_strb_i  = strb;
    cmd_prot_i  = prot;
    step();
    // Scramble the command inputs so that unregistered fields would show up.
    cmd_valid_i = 1'b0;
    cmd_addr_i  = ~addr;
    cmd_write_i = ~wr;
    cmd_wdata_i = $urandom;
    cmd_strb_i  = ~strb;
    cmd_prot_i  = ~prot;
    chk("setup_ctl", {61'd0, psel, penable, cmd_ready}, 64'b100);
    chk("setup_addr_data", {paddr, pwdata}, {addr, wdata});
    chk("setup_attr", {56'd0, pwrite, e_strb, prot}, {56'd0, wr, e_strb, prot});
    step();
    acc = 0;
    while (psel && penable && acc < 40) begin
      acc++;
      chk("access_addr_data", {paddr, pwdata}, {addr, wdata});
      chk("access_attr", {54'd0, pwrite, pstrb, pprot, rsp_valid, cmd_ready},
          {54'd0, wr, e_strb, prot, 2'b00});
      pready_i  = ((acc - 1) == wait_n);
      pslverr_i = pready_i ? perr : 1'($urandom_range(0, 1));
      prdata_i  = pready_i ? prd : $urandom;
      step();
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = $urandom;
    chk("access_cycles", 64'(acc), 64'(e_acc));
    for (int i = 0; i <= bp; i++) begin
      chk("rsp_flags", {58'd0, rsp_valid, psel, penable, cmd_ready, rsp_err, rsp_timeout},
          {58'd0, 4'b1000, e_err, e_tout});
      chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e_rdata});
      rsp_ready_i = (i == bp);
      step();
    end
    rsp_ready_i = 1'b0;
    chk("back_to_idle", {61'd0, rsp_valid, psel, cmd_ready}, 64'b001);
  endtask

  // Brings whichever instance was not under test back to IDLE.
  task automatic drain();
    pready_i    = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (4) step();
    pready_i    = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_n;
    logic [31:0] prd;
    logic        perr;
    int          bp;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_tout;
    int          e_acc;
  } vec_t;

  vec_t vt[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e, t, wr, perr;
    int          acc, wn, to;
    logic [31:0] addr, wdata, prd;
    logic [3:0]  strb;
    logic [2:0]  prot;

    vt[0] = '{1'b0, 32'h0000_000C, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 32'hAAAA_5555, 1'b0, 0,
              32'h0, 1'b0, 1'b0, 1};
    vt[1] = '{1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, apb4_pkg::PROT_PRIV, 5, 32'h1234_5678, 1'b0, 0,
              32'h1234_5678, 1'b0, 1'b0, 6};
    vt[2] = '{1'b0, 32'h0000_0200, 1'b1, 32'h0102_0304, 4'h5, apb4_pkg::PROT_NSEC, 1, 32'h5555_0000, 1'b1, 0,
              32'h0, 1'b1, 1'b0, 2};
    vt[3] = '{1'b0, 32'h0000_0204, 1'b0, 32'h7777_7777, 4'hF, apb4_pkg::PROT_INSTR | apb4_pkg::PROT_PRIV,
              0, 32'hCAFE_F00D, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 1};
    vt[4] = '{1'b1, 32'h0000_0300, 1'b0, 32'h0, 4'hF, 3'b000, 100, 32'hBADC_AB1E, 1'b0, 0,
              32'h0, 1'b1, 1'b1, 4};
    vt[5] = '{1'b1, 32'h0000_0304, 1'b0, 32'h0, 4'hF, 3'b000, 3, 32'h0BAD_F00D, 1'b0, 0,
              32'h0BAD_F00D, 1'b0, 1'b0, 4};
    vt[6] = '{1'b1, 32'h0000_0308, 1'b1, 32'h55AA_55AA, 4'h3, 3'b000, 4, 32'h0, 1'b0, 0,
              32'h0, 1'b1, 1'b1, 4};
    vt[7] = '{1'b0, 32'h0000_030C, 1'b0, 32'h0, 4'hF, 3'b000, 2, 32'h1122_3344, 1'b0, 3,
              32'h1122_3344, 1'b0, 1'b0, 3};

    sel_b       = 1'b0;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = 32'h0;
    cmd_write_i = 1'b0;
    cmd_wdata_i = 32'h0;
    cmd_strb_i  = 4'h0;
    cmd_prot_i  = 3'h0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    prdata_i    = 32'h0;
    pslverr_i   = 1'b0;
    repeat (2) step();

    for (int s = 0; s < 2; s++) begin
      sel_b = s[0];
      #1;
      chk("reset_ctl", {48'd0, cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout,
          pstrb, pprot, 2'b00}, {48'd0, 1'b1, 15'd0});
      chk("reset_addr_wdata", {paddr, pwdata}, 64'd0);
      chk("reset_rdata", {32'd0, rsp_rdata}, 64'd0);
    end
    sel_b = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      sel_b = vt[i].sel;
      xfer(vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].strb, vt[i].prot, vt[i].wait_n, vt[i].prd,
           vt[i].perr, vt[i].bp, vt[i].e_rdata, vt[i].e_err, vt[i].e_tout, vt[i].e_acc);
      drain();
    end

    // Reset in the middle of ACCESS abandons the transfer.
    sel_b       = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 32'h0000_0400;
    cmd_write_i = 1'b0;
    cmd_prot_i  = 3'b000;
    step();
    cmd_valid_i = 1'b0;
    step();
    chk("pre_reset_access", {62'd0, psel, penable}, 64'b11);
    rst_i = 1'b1;
    step();
    chk("post_reset_ctl", {61'd0, psel, penable, rsp_valid}, 64'b000);
    chk("post_reset_addr", {32'd0, paddr}, 64'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_no_rsp", {62'd0, rsp_valid, cmd_ready}, 64'b01);
      step();
    end
    xfer(32'h0000_0404, 1'b0, 32'h0, 4'hF, apb4_pkg::PROT_NSEC, 1, 32'h600D_D00D, 1'b0, 1,
         32'h600D_D00D, 1'b0, 1'b0, 2);
    drain();

    for (int n = 0; n < 40; n++) begin
      sel_b = 1'($urandom_range(0, 1));
      to    = sel_b ? TO_B : TO_A;
      wr    = 1'($urandom_range(0, 1));
      perr  = 1'($urandom_range(0, 1));
      wn    = int'($urandom_range(0, 6));
      addr  = $urandom & 32'hFFFF_FFFC;
      wdata = $urandom;
      prd   = $urandom;
      strb  = 4'($urandom_range(0, 15));
      prot  = 3'($urandom_range(0, 7));
      model(to, wr, wn, prd, perr, r, e, t, acc);
      xfer(addr, wr, wdata, strb, prot, wn, prd, perr, int'($urandom_range(0, 2)), r, e, t, acc);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
